uart_host_if: RTL and testbench
===============================

Name: uart_host_if

Overview:
- Host-side bus cycle generator for the dual UART register interface.
- Accepts single register read/write requests on a valid/ready handshake from the host core.
- Drives cs_0/cs_1, a, rd_, wr_ and the shared tri-state dbus with programmable setup, strobe and hold timing.
- Returns read data and write completion on a one-cycle response pulse.

Parameters:
- SETUP_CYC, 1: cycles with cs and a valid before the strobe asserts; legal range 1..15.
- STROBE_CYC, 2: cycles with rd_ or wr_ low; legal range 1..15.
- HOLD_CYC, 1: cycles after the strobe releases with cs, a and write data held; legal range 1..15.

Ports:
- clkin  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready at a clkin edge.
- req_we  input  1  1 = write, 0 = read.
- req_chan  input  1  0 selects cs_0, 1 selects cs_1.
- req_a  input  3  register address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data; valid with rsp_valid for reads.
- busy  output  1  bus cycle in progress.
- dbus  inout  8  shared data bus; driven only during write cycles.
- a  output  3  register address to the UART.
- rd_  output  1  active-low read strobe.
- wr_  output  1  active-low write strobe.
- cs_0  output  1  active-high chip select, UART 0.
- cs_1  output  1  active-high chip select, UART 1.

Behaviour:
- Reset values (asynchronous, while reset = 0): state IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 8'h00; busy = 0; a = 0; rd_ = 1; wr_ = 1; cs_0 = 0; cs_1 = 0; dbus = Z.
- Request/address/data/chan/we are registered on accept. Outputs are registered, glitch-free, and come only from state and registers.
- State machine:
  - IDLE: req_ready = 1. On accept, go to SETUP with the counter loaded.
  - SETUP: runs SETUP_CYC cycles. The selected cs is 1 and a is valid. rd_ = wr_ = 1. For writes, dbus is driven.
  - STROBE: runs STROBE_CYC cycles. rd_ is 0 for reads, wr_ is 0 for writes. cs, a and write data are held.
  - HOLD: runs HOLD_CYC cycles. Strobes are 1; cs, a and write data are held. On expiry, go to IDLE.
- The dbus output enable is 1 only in SETUP, STROBE and HOLD of a write. The bus is never driven during a read or in IDLE.
- Read capture: dbus is sampled into rsp_rdata on the clkin edge that ends the last STROBE cycle.
- Response: rsp_valid = 1 for exactly one cycle on entry to IDLE after HOLD, for both reads and writes. On a write, rsp_rdata is unchanged.
- Latency: accept edge + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles to rsp_valid. Default is 4.
- Back-to-back: req_ready is high in the rsp_valid cycle, so a new accept may coincide with it. There is a minimum of one IDLE cycle between bus cycles, which gives cs deassert and bus turnaround.
- busy = 1 in SETUP, STROBE and HOLD.
- Counter: 4-bit down-counter, reloaded at each phase entry. The phase ends when the count reaches 1.
- The cs not selected by req_chan stays 0. cs_0 and cs_1 are never both 1.
- Reset mid-cycle: strobes and cs deassert immediately, dbus releases, no rsp_valid is issued, and the request is dropped.
- req_valid while not IDLE: ignored (req_ready = 0). The requester holds its signals stable until accepted.

Optional Feature:
- Macro: UART_HOST_IRQ_SYNC_EN.
- Defined:
  - Adds inputs int0 and int1, and outputs irq (1 bit) and irq_src (2 bits).
  - Each int goes through a two-flop synchronizer (reset 0).
  - irq_src = {int1_sync, int0_sync}; irq = |irq_src, registered.
  - Latency is 3 clkin cycles from int change to irq change.
- Undefined: none of these ports or flops exist.

Decomposition:
- Shared package uart_host_pkg:
  - State encoding: IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3.
  - Counter width 4.
  - UART register address width 3.
  - Data width 8.
- Sub-module uart_host_sync2: a two-flop synchronizer with async active-low reset, instantiated twice when UART_HOST_IRQ_SYNC_EN is defined.

Test Plan:
- Reset release, then a write with chan 0, a = 3'd3, wdata = 8'h83 (defaults):
  - cs_0 = 1 for 4 cycles.
  - wr_ = 0 for 2 cycles, starting 1 cycle after cs_0 rises.
  - dbus = 8'h83 throughout; cs_1 = 0.
  - rsp_valid pulses on the 5th cycle after accept.
- Read with chan 1, a = 3'd5, while the UART model drives 8'h60:
  - rd_ = 0 for 2 cycles; dbus is never driven by the DUT.
  - rsp_rdata = 8'h60 with rsp_valid.
- Back-to-back: write then read with req_valid held high:
  - The second accept coincides with the first rsp_valid.
  - Exactly 1 IDLE cycle with all cs = 0 between the cycles.
- Parameters SETUP_CYC = 3, STROBE_CYC = 5, HOLD_CYC = 2:
  - Strobe width is 5 cycles and rsp_valid arrives 10 cycles after accept.
- Assert reset in the 2nd STROBE cycle of a write:
  - Same cycle: wr_ = 1, cs_0 = 0, dbus = Z.
  - No rsp_valid after release; the next request completes normally.
- With UART_HOST_IRQ_SYNC_EN defined, pulse int1 high:
  - irq_src = 2'b10 and irq = 1 three cycles later.
  - Both clear three cycles after int1 falls.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared types and widths for the UART host bus cycle generator.
package uart_host_pkg;

    localparam int CNT_W  = 4;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_t;

    function automatic logic [CNT_W-1:0] cyc_to_cnt(input int unsigned cyc);
        return cyc[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/uart_host_sync2.sv
// Two-flop synchronizer for asynchronous UART interrupt lines.
module uart_host_sync2 (
    input  logic clkin,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_host_if.sv
// Host-side bus cycle generator for the dual UART register interface.
// Optional interrupt synchronizers are enabled by defining UART_HOST_IRQ_SYNC_EN.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// SETUP  | cs and a valid, strobes inactive, write data driven
// STROBE | rd_ or wr_ low
// HOLD   | strobes released, cs/a/write data still held
module uart_host_if
    import uart_host_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_chan,
    input  logic [ADDR_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    inout  wire  [DATA_W-1:0] dbus,
    output logic [ADDR_W-1:0] a,
    output logic              rd_,
    output logic              wr_,
    output logic              cs_0,
    output logic              cs_1
`ifdef UART_HOST_IRQ_SYNC_EN
    ,
    input  logic              int0,
    input  logic              int1,
    output logic              irq,
    output logic [1:0]        irq_src
`endif
);

    localparam logic [CNT_W-1:0] SETUP_LD  = cyc_to_cnt(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = cyc_to_cnt(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = cyc_to_cnt(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = cyc_to_cnt(1);

    bus_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              dbus_oe;
    logic [DATA_W-1:0] wdata_q;

    assign dbus = dbus_oe ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dbus_oe   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            a         <= '0;
            rd_       <= 1'b1;
            wr_       <= 1'b1;
            cs_0      <= 1'b0;
            cs_1      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= SETUP;
                        cnt       <= SETUP_LD;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        a         <= req_a;
                        dbus_oe   <= req_we;
                        cs_0      <= ~req_chan;
                        cs_1      <= req_chan;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_ONE) begin
                        state <= STROBE;
                        cnt   <= STROBE_LD;
                        rd_   <= we_q;
                        wr_   <= ~we_q;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STROBE: begin
                    if (cnt == CNT_ONE) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                        rd_   <= 1'b1;
                        wr_   <= 1'b1;
                        // UART data is still valid on the edge that releases rd_
                        if (!we_q) begin
                            rsp_rdata <= dbus;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_ONE) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        dbus_oe   <= 1'b0;
                        cs_0      <= 1'b0;
                        cs_1      <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

`ifdef UART_HOST_IRQ_SYNC_EN
    logic int0_sync;
    logic int1_sync;

    uart_host_sync2 u_sync_int0 (
        .clkin (clkin),
        .reset (reset),
        .d     (int0),
        .q     (int0_sync)
    );

    uart_host_sync2 u_sync_int1 (
        .clkin (clkin),
        .reset (reset),
        .d     (int1),
        .q     (int1_sync)
    );

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            irq_src <= 2'b00;
            irq     <= 1'b0;
        end else begin
            irq_src <= {int1_sync, int0_sync};
            irq     <= int1_sync | int0_sync;
        end
    end
`endif

endmodule

// File: tb/tb_uart_host_if.sv
// Directed self-checking bench for uart_host_if (default and stretched timing instances).
module tb_uart_host_if;

    logic       clkin;
    logic       reset;
    logic       req_valid;
    logic       req_valid2;
    logic       req_we;
    logic       req_chan;
    logic [2:0] req_a;
    logic [7:0] req_wdata;
    logic [7:0] uart_data;

    logic       req_ready, rsp_valid, busy, rd_, wr_, cs_0, cs_1;
    logic [7:0] rsp_rdata;
    logic [2:0] a;
    wire  [7:0] dbus;

    logic       req_ready2, rsp_valid2, busy2, rd2_, wr2_, cs2_0, cs2_1;
    logic [7:0] rsp_rdata2;
    logic [2:0] a2;
    wire  [7:0] dbus2;

`ifdef UART_HOST_IRQ_SYNC_EN
    logic       int0, int1, irq, irq2;
    logic [1:0] irq_src, irq_src2;
`endif

    int checks;
    int errors;

    // UART models drive the bus only while their read strobe is low
    assign dbus  = (!rd_)  ? uart_data : 8'hzz;
    assign dbus2 = (!rd2_) ? 8'h5A     : 8'hzz;

    uart_host_if dut (
        .clkin(clkin), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_chan(req_chan), .req_a(req_a), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .dbus(dbus), .a(a), .rd_(rd_), .wr_(wr_), .cs_0(cs_0), .cs_1(cs_1)
`ifdef UART_HOST_IRQ_SYNC_EN
        , .int0(int0), .int1(int1), .irq(irq), .irq_src(irq_src)
`endif
    );

    uart_host_if #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2)) dut2 (
        .clkin(clkin), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
        .req_chan(req_chan), .req_a(req_a), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .dbus(dbus2), .a(a2), .rd_(rd2_), .wr_(wr2_), .cs_0(cs2_0), .cs_1(cs2_1)
`ifdef UART_HOST_IRQ_SYNC_EN
        , .int0(int0), .int1(int1), .irq(irq2), .irq_src(irq_src2)
`endif
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        logic [7:0] obs;
        repeat (2) @(posedge clkin);
        #1;
        obs = {cs_0, cs_1, wr_, rd_, busy, rsp_valid, req_ready, dut.dbus_oe};
        checks++;
        if (obs !== 8'b0011_0010) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", obs, 8'b0011_0010);
        end
        checks++;
        if (rsp_rdata !== 8'h00 || a !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: rdata %h a %0d expected 00 and 0", rsp_rdata, a);
        end
        obs = {cs2_0, cs2_1, wr2_, rd2_, busy2, rsp_valid2, req_ready2, dut2.dbus_oe};
        checks++;
        if (obs !== 8'b0011_0010) begin
            errors++;
            $display("FAIL reset_ctrl2: got %b expected %b", obs, 8'b0011_0010);
        end
        reset = 1'b1;
        @(posedge clkin);
        #1;
    endtask

    task automatic test_write();
        logic [7:0] obs, exp;
        req_we = 1'b1; req_chan = 1'b0; req_a = 3'd3; req_wdata = 8'h83; req_valid = 1'b1;
        @(posedge clkin);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            obs = {cs_0, cs_1, wr_, rd_, busy, rsp_valid, req_ready, dut.dbus_oe};
            exp = {(k <= 4), 1'b0, !(k == 2 || k == 3), 1'b1, (k <= 4), (k == 5), (k >= 5), (k <= 4)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL write_ctrl cycle %0d: got %b expected %b", k, obs, exp);
            end
            if (k <= 4) begin
                checks++;
                if (dbus !== 8'h83 || a !== 3'd3) begin
                    errors++;
                    $display("FAIL write_bus cycle %0d: dbus %h a %0d expected 83 and 3", k, dbus, a);
                end
            end
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic test_read();
        logic [7:0] obs, exp;
        uart_data = 8'h60;
        req_we = 1'b0; req_chan = 1'b1; req_a = 3'd5; req_valid = 1'b1;
        @(posedge clkin);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            obs = {cs_0, cs_1, wr_, rd_, busy, rsp_valid, req_ready, dut.dbus_oe};
            exp = {1'b0, (k <= 4), 1'b1, !(k == 2 || k == 3), (k <= 4), (k == 5), (k >= 5), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL read_ctrl cycle %0d: got %b expected %b", k, obs, exp);
            end
            if (k <= 4) begin
                checks++;
                if (a !== 3'd5) begin
                    errors++;
                    $display("FAIL read_addr cycle %0d: got %0d expected 5", k, a);
                end
            end
            if (k == 5) begin
                checks++;
                if (rsp_rdata !== 8'h60) begin
                    errors++;
                    $display("FAIL read_data: got %h expected 60", rsp_rdata);
                end
            end
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs, exp;
        uart_data = 8'h3C;
        req_we = 1'b1; req_chan = 1'b0; req_a = 3'd1; req_wdata = 8'hA5; req_valid = 1'b1;
        @(posedge clkin);
        #1;
        req_we = 1'b0; req_chan = 1'b1; req_a = 3'd2;
        for (int k = 1; k <= 10; k++) begin
            obs = {cs_0, cs_1, wr_, rd_, busy, rsp_valid, req_ready, dut.dbus_oe};
            exp = {(k <= 4), (k >= 6 && k <= 9), !(k == 2 || k == 3), !(k == 7 || k == 8),
                   (k <= 4 || (k >= 6 && k <= 9)), (k == 5 || k == 10), (k == 5 || k == 10), (k <= 4)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_ctrl cycle %0d: got %b expected %b", k, obs, exp);
            end
            if (k == 5) begin
                checks++;
                if (rsp_rdata !== 8'h60) begin
                    errors++;
                    $display("FAIL b2b_write_rdata: got %h expected 60 (unchanged)", rsp_rdata);
                end
            end
            if (k == 6) req_valid = 1'b0;
            if (k == 10) begin
                checks++;
                if (rsp_rdata !== 8'h3C) begin
                    errors++;
                    $display("FAIL b2b_read_data: got %h expected 3c", rsp_rdata);
                end
            end
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic test_params();
        int strobe_cnt, cs_cnt, rsp_at, strobe_first;
        strobe_cnt = 0; cs_cnt = 0; rsp_at = 0; strobe_first = 0;
        req_we = 1'b0; req_chan = 1'b0; req_a = 3'd7; req_valid2 = 1'b1;
        @(posedge clkin);
        #1;
        req_valid2 = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (!rd2_) begin
                strobe_cnt++;
                if (strobe_first == 0) strobe_first = k;
            end
            if (cs2_0) cs_cnt++;
            if (rsp_valid2 && rsp_at == 0) begin
                rsp_at = k;
                checks++;
                if (rsp_rdata2 !== 8'h5A) begin
                    errors++;
                    $display("FAIL param_rdata: got %h expected 5a", rsp_rdata2);
                end
            end
            @(posedge clkin);
            #1;
        end
        checks++;
        if (strobe_cnt != 5 || strobe_first != 4) begin
            errors++;
            $display("FAIL param_strobe: width %0d start %0d expected 5 and 4", strobe_cnt, strobe_first);
        end
        checks++;
        if (cs_cnt != 10) begin
            errors++;
            $display("FAIL param_cs_width: got %0d expected 10", cs_cnt);
        end
        checks++;
        if (rsp_at != 11) begin
            errors++;
            $display("FAIL param_latency: rsp in cycle %0d expected 11 (10 edges after accept)", rsp_at);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        int rsp_seen, rsp_at;
        req_we = 1'b1; req_chan = 1'b0; req_a = 3'd4; req_wdata = 8'hC3; req_valid = 1'b1;
        @(posedge clkin);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clkin);
            #1;
        end
        checks++;
        if (wr_ !== 1'b0 || cs_0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: wr_ %b cs_0 %b expected 0 and 1", wr_, cs_0);
        end
        reset = 1'b0;
        #1;
        obs = {cs_0, wr_, busy, dut.dbus_oe, rsp_valid, req_ready};
        checks++;
        if (obs !== 6'b010001) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", obs, 6'b010001);
        end
        repeat (2) @(posedge clkin);
        #1;
        reset = 1'b1;
        rsp_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clkin);
            #1;
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0) begin
            errors++;
            $display("FAIL mid_no_rsp: got %0d pulses expected 0", rsp_seen);
        end
        uart_data = 8'h99;
        req_we = 1'b0; req_chan = 1'b0; req_a = 3'd2; req_valid = 1'b1;
        @(posedge clkin);
        #1;
        req_valid = 1'b0;
        rsp_at = 0;
        for (int k = 1; k <= 8; k++) begin
            if (rsp_valid && rsp_at == 0) rsp_at = k;
            @(posedge clkin);
            #1;
        end
        checks++;
        if (rsp_at != 5 || rsp_rdata !== 8'h99) begin
            errors++;
            $display("FAIL mid_recover: rsp cycle %0d data %h expected 5 and 99", rsp_at, rsp_rdata);
        end
    endtask

`ifdef UART_HOST_IRQ_SYNC_EN
    task automatic test_irq();
        int1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clkin);
            #1;
            checks++;
            if (irq !== (k >= 3) || irq_src !== ((k >= 3) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL irq_rise cycle %0d: irq %b src %b", k, irq, irq_src);
            end
        end
        int1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clkin);
            #1;
            checks++;
            if (irq !== (k < 3) || irq_src !== ((k < 3) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL irq_fall cycle %0d: irq %b src %b", k, irq, irq_src);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_valid2 = 1'b0;
        req_we = 1'b0;
        req_chan = 1'b0;
        req_a = 3'd0;
        req_wdata = 8'h00;
        uart_data = 8'h00;
`ifdef UART_HOST_IRQ_SYNC_EN
        int0 = 1'b0;
        int1 = 1'b0;
`endif
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_params();
        test_reset_mid();
`ifdef UART_HOST_IRQ_SYNC_EN
        test_irq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
